// File: rtl/bp_be_rec_to_fp_pipe_if.sv
// Bundle of the conversion pipe's request/result signals.
//
// Signals
//   v_i          request valid
//   rec_i        65-bit DP-recoded value {sign, exp[11:0], sig[51:0]}
//   sp_not_dp_i  request is a single-precision value held in DP-recoded form
//   clear_i      synchronous clear of the delivered-results counter
//   v_o          result valid
//   raw_o        IEEE-754 raw bits (SP results NaN-boxed into 64 bits)
//   count_o      number of results delivered (wrapping)
//
// Modports
//   master  producer side (drives requests, observes results)
//   slave   the converter itself
interface bp_be_rec_to_fp_pipe_if #(
    parameter int count_width_p = 31
);
    logic                     v_i;
    logic [64:0]              rec_i;
    logic                     sp_not_dp_i;
    logic                     clear_i;
    logic                     v_o;
    logic [63:0]              raw_o;
    logic [count_width_p-1:0] count_o;

    modport master (
        output v_i,
        output rec_i,
        output sp_not_dp_i,
        output clear_i,
        input  v_o,
        input  raw_o,
        input  count_o
    );

    modport slave (
        input  v_i,
        input  rec_i,
        input  sp_not_dp_i,
        input  clear_i,
        output v_o,
        output raw_o,
        output count_o
    );
endinterface

// File: rtl/bp_be_rec_to_fp_pipe.sv
// Pipelined converter from HardFloat recoded floating point (65-bit
// DP-recoded register format) to IEEE-754 raw bits. Single-precision
// values held in DP-recoded form are converted to a 32-bit word and
// NaN-boxed into 64 bits. The conversion is done combinationally on the
// input side and then carried through a fixed-latency valid/data delay
// chain with no stall. A wrapping counter tallies delivered results.
//
// Parameters
//   latency_p    register stages from input to output (>= 1)
//   max_count_p  largest counter value before wrapping to zero
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   reset_n_i    asynchronous active-low reset
//   io           request/result bundle (slave side), see the interface
module bp_be_rec_to_fp_pipe #(
    parameter  int latency_p     = 4,
    parameter  int max_count_p   = 2**30,
    localparam int count_width_p = $clog2(max_count_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_be_rec_to_fp_pipe_if.slave  io
);

    // Value classes, decoded from the three most significant exponent bits
    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_FINITE,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Recoded exponent offsets. A recoded exponent of 1025 corresponds to
    // the DP subnormal/normal boundary (biased exponent 0), so normal DP
    // values start at 1026. For SP the boundary sits 1792 higher in the
    // SP-relative scale: Es = E - 1792, normal from Es = 130, i.e. E = 1922.
    localparam logic [11:0] DP_SUB_BASE = 12'd1025;
    localparam logic [11:0] DP_NORM_MIN = 12'd1026;
    localparam logic [11:0] SP_SUB_BASE = 12'd1921;
    localparam logic [11:0] SP_NORM_MIN = 12'd1922;

    logic        sign;
    logic [11:0] exp_rec;
    logic [51:0] sig;
    logic [22:0] sp_frac;
    fp_class_e   val_class;

    logic [10:0] dp_norm_exp;
    logic [11:0] dp_sub_shift;
    logic [51:0] dp_sub_frac;
    logic [63:0] dp_word;

    logic [7:0]  sp_norm_exp;
    logic [11:0] sp_sub_shift;
    logic [22:0] sp_sub_frac;
    logic [31:0] sp_word;

    logic [63:0] conv_raw;

    logic        v_q   [latency_p];
    logic [63:0] raw_q [latency_p];

    logic [count_width_p-1:0] count_q;
    logic                     v_last;

    // Field split and class decode of the incoming recoded value
    always_comb begin
        sign    = io.rec_i[64];
        exp_rec = io.rec_i[63:52];
        sig     = io.rec_i[51:0];
        sp_frac = sig[51:29];
        case (exp_rec[11:9])
            3'b000:  val_class = CLS_ZERO;
            3'b110:  val_class = CLS_INF;
            3'b111:  val_class = CLS_NAN;
            default: val_class = CLS_FINITE;
        endcase
    end

    // Double-precision result. Subnormals reinsert the hidden one, drop one
    // bit to align with the 52-bit fraction field, then denormalise by the
    // distance below the normal range; large shift amounts simply flush to 0.
    always_comb begin
        dp_norm_exp  = 11'(exp_rec - DP_SUB_BASE);
        dp_sub_shift = DP_SUB_BASE - exp_rec;
        dp_sub_frac  = {1'b1, sig[51:1]} >> dp_sub_shift;
        dp_word      = '0;
        case (val_class)
            CLS_ZERO: dp_word = {sign, 63'b0};
            CLS_INF:  dp_word = {sign, 11'h7FF, 52'b0};
            CLS_NAN:  dp_word = {sign, 11'h7FF, sig};
            default: begin
                if (exp_rec >= DP_NORM_MIN) begin
                    dp_word = {sign, dp_norm_exp, sig};
                end else begin
                    dp_word = {sign, 11'b0, dp_sub_frac};
                end
            end
        endcase
    end

    // Single-precision result, using only the top 23 significand bits.
    // Out-of-range SP inputs below the subnormal window shift to zero.
    always_comb begin
        sp_norm_exp  = 8'(exp_rec - SP_SUB_BASE);
        sp_sub_shift = SP_SUB_BASE - exp_rec;
        sp_sub_frac  = {1'b1, sp_frac[22:1]} >> sp_sub_shift;
        sp_word      = '0;
        case (val_class)
            CLS_ZERO: sp_word = {sign, 31'b0};
            CLS_INF:  sp_word = {sign, 8'hFF, 23'b0};
            CLS_NAN:  sp_word = {sign, 8'hFF, sp_frac};
            default: begin
                if (exp_rec >= SP_NORM_MIN) begin
                    sp_word = {sign, sp_norm_exp, sp_frac};
                end else begin
                    sp_word = {sign, 8'b0, sp_sub_frac};
                end
            end
        endcase
    end

    // SP results are NaN-boxed so the register-file view stays 64 bits wide
    always_comb begin
        conv_raw = dp_word;
        if (io.sp_not_dp_i) begin
            conv_raw = {32'hFFFF_FFFF, sp_word};
        end
    end

    // Delay chain: stage 0 captures the fresh conversion and every later
    // stage copies its predecessor each cycle, valid or not, so throughput
    // is one result per cycle with a fixed latency.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < latency_p; k++) begin
                v_q[k]   <= 1'b0;
                raw_q[k] <= '0;
            end
        end else begin
            v_q[0]   <= io.v_i;
            raw_q[0] <= conv_raw;
            for (int k = 1; k < latency_p; k++) begin
                v_q[k]   <= v_q[k-1];
                raw_q[k] <= raw_q[k-1];
            end
        end
    end

    assign v_last = v_q[latency_p-1];

    // Delivered-results counter. A clear takes priority but still counts a
    // result delivered in the same cycle, so clear plus delivery yields 1.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (io.clear_i) begin
            count_q <= count_width_p'(v_last);
        end else if (v_last) begin
            if (count_q == count_width_p'(max_count_p)) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign io.v_o     = v_last;
    assign io.raw_o   = raw_q[latency_p-1];
    assign io.count_o = count_q;

endmodule

// File: tb/tb_bp_be_rec_to_fp_pipe.sv
// Testbench for bp_be_rec_to_fp_pipe: table of recoded inputs with their
// IEEE results, a scoreboard queue filled on issue and drained on v_o, a
// counter reference, and hand sequences for latency, clear, wrap and reset.
module tb_bp_be_rec_to_fp_pipe;

    localparam int LAT  = 4;
    localparam int MAXC = 3;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int NV   = 17;

    typedef struct {
        logic [64:0] rec;
        logic        sp;
        logic [63:0] raw;
        string       name;
    } vec_t;

    typedef struct {
        logic [63:0] raw;
        int          cyc;
    } sb_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    int   cyc;

    vec_t          vecs [NV];
    sb_t           sb [$];
    logic [CW-1:0] cntModel;

    bp_be_rec_to_fp_pipe_if #(.count_width_p(CW)) io ();

    bp_be_rec_to_fp_pipe #(
        .latency_p   (LAT),
        .max_count_p (MAXC)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (io)
    );

    // Free-running clock and a cycle index for latency measurement
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Overall time bound so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle's worth of inputs just after a rising edge; issued
    // requests push their expected result onto the scoreboard.
    task automatic applyStimulus(input logic [64:0] rec, input logic sp,
                                 input logic valid, input logic clr,
                                 input logic [63:0] expRaw);
        @(posedge clk);
        #1;
        io.v_i         = valid;
        io.rec_i       = rec;
        io.sp_not_dp_i = sp;
        io.clear_i     = clr;
        if (valid) sb.push_back('{raw: expRaw, cyc: cyc});
    endtask

    task automatic idleCycle(input logic clr);
        applyStimulus(65'h0, 1'b0, 1'b0, clr, 64'h0);
    endtask

    task automatic sendBurst(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(vecs[i % NV].rec, vecs[i % NV].sp, 1'b1, 1'b0, vecs[i % NV].raw);
        end
        repeat (LAT + 1) idleCycle(1'b0);
    endtask

    // Output monitor: compares every delivered result against the scoreboard,
    // checks its latency, and tracks the expected counter value.
    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            cntModel = '0;
        end else begin
            checkOutput("count_o", 64'(io.count_o), 64'(cntModel));
            if (io.v_o) begin
                if (sb.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("[TB] FAIL unexpected_v_o: got v_o=1 raw=%h, expected no output", io.raw_o);
                end else begin
                    e = sb.pop_front();
                    checkOutput("raw_o", io.raw_o, e.raw);
                    checkOutput("latency", 64'(cyc - e.cyc), 64'(LAT));
                end
            end
            if (io.clear_i) begin
                cntModel = CW'(io.v_o);
            end else if (io.v_o) begin
                cntModel = (int'(cntModel) == MAXC) ? '0 : cntModel + 1'b1;
            end
        end
    end

    initial begin
        int expCount;
        errors = 0;
        checks = 0;

        vecs[0]  = '{65'h0_8000_0000_0000_0000, 1'b0, 64'h3FF0_0000_0000_0000, "dp_one"};
        vecs[1]  = '{65'h0_8000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_3F80_0000, "sp_one"};
        vecs[2]  = '{65'h1_0000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, "dp_neg_zero"};
        vecs[3]  = '{{1'b0, 12'hC00, 52'h0}, 1'b0, 64'h7FF0_0000_0000_0000, "dp_pos_inf"};
        vecs[4]  = '{{1'b0, 12'hE00, 52'h8_0000_0000_0000}, 1'b0, 64'h7FF8_0000_0000_0000, "dp_qnan"};
        vecs[5]  = '{{1'b0, 12'd1025, 52'h0}, 1'b0, 64'h0008_0000_0000_0000, "dp_sub_1025"};
        vecs[6]  = '{{1'b0, 12'd974, 52'h0}, 1'b0, 64'h0000_0000_0000_0001, "dp_sub_974"};
        vecs[7]  = '{{1'b1, 12'h801, 52'h4_0000_0000_0000}, 1'b0, 64'hC004_0000_0000_0000, "dp_neg_2p5"};
        vecs[8]  = '{{1'b1, 12'hC00, 52'h0}, 1'b1, 64'hFFFF_FFFF_FF80_0000, "sp_neg_inf"};
        vecs[9]  = '{{1'b0, 12'hE00, 52'h8_0000_0000_0000}, 1'b1, 64'hFFFF_FFFF_7FC0_0000, "sp_qnan"};
        vecs[10] = '{{1'b1, 12'h000, 52'h0}, 1'b1, 64'hFFFF_FFFF_8000_0000, "sp_neg_zero"};
        vecs[11] = '{{1'b0, 12'd1922, 52'h0}, 1'b1, 64'hFFFF_FFFF_0080_0000, "sp_min_normal"};
        vecs[12] = '{{1'b0, 12'd1921, 52'h0}, 1'b1, 64'hFFFF_FFFF_0040_0000, "sp_sub_top"};
        vecs[13] = '{{1'b0, 12'hBFF, 52'hF_FFFF_FFFF_FFFF}, 1'b0, 64'h7FEF_FFFF_FFFF_FFFF, "dp_max"};
        vecs[14] = '{{1'b0, 12'h800, 52'h8_0000_0000_0000}, 1'b1, 64'hFFFF_FFFF_3FC0_0000, "sp_1p5"};
        vecs[15] = '{{1'b0, 12'd1024, 52'h8_0000_0000_0000}, 1'b0, 64'h0006_0000_0000_0000, "dp_sub_frac"};
        vecs[16] = '{{1'b0, 12'd1919, 52'h0}, 1'b1, 64'hFFFF_FFFF_0010_0000, "sp_sub_shift2"};

        io.v_i         = 1'b0;
        io.rec_i       = '0;
        io.sp_not_dp_i = 1'b0;
        io.clear_i     = 1'b0;
        reset_n        = 1'b0;
        cntModel       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_v_o", 64'(io.v_o), 64'd0);
        checkOutput("reset_raw_o", io.raw_o, 64'h0);
        checkOutput("reset_count_o", 64'(io.count_o), 64'd0);
        reset_n = 1'b1;

        // Single DP 1.0: output exactly LAT cycles later, count steps 0 -> 1
        applyStimulus(vecs[0].rec, vecs[0].sp, 1'b1, 1'b0, vecs[0].raw);
        for (int k = 1; k < LAT; k++) begin
            idleCycle(1'b0);
            checkOutput("early_v_o", 64'(io.v_o), 64'd0);
        end
        idleCycle(1'b0);
        checkOutput("lat_v_o", 64'(io.v_o), 64'd1);
        checkOutput("lat_raw_o", io.raw_o, 64'h3FF0_0000_0000_0000);
        checkOutput("lat_count_before", 64'(io.count_o), 64'd0);
        idleCycle(1'b0);
        checkOutput("lat_count_after", 64'(io.count_o), 64'd1);
        checkOutput("lat_v_o_drop", 64'(io.v_o), 64'd0);

        // Table of conversions, issued back to back
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].rec, vecs[i].sp, 1'b1, 1'b0, vecs[i].raw);
        end
        repeat (LAT + 2) idleCycle(1'b0);
        expCount = (1 + NV) % (MAXC + 1);
        checkOutput("table_count", 64'(io.count_o), 64'(expCount));
        checkOutput("table_drained", 64'(sb.size()), 64'd0);

        // Clear without a delivery, then count up to the maximum and wrap
        idleCycle(1'b1);
        idleCycle(1'b0);
        checkOutput("clear_idle", 64'(io.count_o), 64'd0);
        sendBurst(3);
        checkOutput("count_max", 64'(io.count_o), 64'd3);
        sendBurst(1);
        checkOutput("count_wrap", 64'(io.count_o), 64'd0);
        sendBurst(2);
        checkOutput("count_two", 64'(io.count_o), 64'd2);

        // Clear in the same cycle as a delivery yields 1
        applyStimulus(vecs[1].rec, vecs[1].sp, 1'b1, 1'b0, vecs[1].raw);
        repeat (LAT - 1) idleCycle(1'b0);
        idleCycle(1'b1);
        checkOutput("clear_v_o", 64'(io.v_o), 64'd1);
        idleCycle(1'b0);
        checkOutput("clear_with_v_o", 64'(io.count_o), 64'd1);
        checkOutput("pre_reset_drained", 64'(sb.size()), 64'd0);

        // Ten back-to-back requests, reset while the tail is still in flight
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rec, vecs[i].sp, 1'b1, 1'b0, vecs[i].raw);
        end
        @(posedge clk);
        #1;
        io.v_i  = 1'b0;
        reset_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("midreset_v_o", 64'(io.v_o), 64'd0);
        checkOutput("midreset_raw_o", io.raw_o, 64'h0);
        checkOutput("midreset_count", 64'(io.count_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            idleCycle(1'b0);
            checkOutput("post_reset_v_o", 64'(io.v_o), 64'd0);
        end
        checkOutput("post_reset_count", 64'(io.count_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
